// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. It steps one instruction at a
// time through fetch/decode/execute/memory/writeback, with a mem_ready handshake and an optional timeout.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       link,
    output logic       Arith_u,
    output logic [3:0] ByteControl,
    output logic [4:0] alu_opcode,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP   = 4'd11,
        JREG   = 4'd12
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state, timeout, unsigned_load;

    function automatic logic [3:0] byte_ctl(input logic [5:0] op);
        case (op)
            6'd35, 6'd43:        byte_ctl = 4'b1111;
            6'd33, 6'd37, 6'd41: byte_ctl = 4'b0011;
            default:             byte_ctl = 4'b0001;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu(input logic [5:0] op);
        case (op)
            6'd10:   imm_alu = 5'b00111;
            6'd11:   imm_alu = 5'b01000;
            6'd12:   imm_alu = 5'b00100;
            6'd13:   imm_alu = 5'b00101;
            6'd14:   imm_alu = 5'b00110;
            6'd15:   imm_alu = 5'b01001;
            default: imm_alu = 5'b00000;
        endcase
    endfunction

    assign mem_state     = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign unsigned_load = (opcode == 6'd36) || (opcode == 6'd37);
    assign timeout       = (MAX_WAIT != 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

    // The counter also clears on a timeout, because a timed-out fetch stays in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || timeout)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        PCSrc       = 2'b00;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        link        = 1'b0;
        Arith_u     = 1'b0;
        ByteControl = 4'b0000;
        alu_opcode  = 5'b00000;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    AluSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        state_next = DECODE;
                    end else if (timeout) begin
                        bus_err = 1'b1;
                    end
                end
                DECODE: begin
                    AluSrcB = 2'b11;
                    case (opcode)
                        6'd0:  state_next = (funct == 6'd8 || funct == 6'd9) ? JREG : EXEC;
                        6'd28: state_next = EXEC;
                        6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43:
                               state_next = MEMADR;
                        6'd1, 6'd4, 6'd5, 6'd6, 6'd7:
                               state_next = BRANCH;
                        6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15:
                               state_next = IEXEC;
                        6'd2, 6'd3:
                               state_next = JUMP;
                        default: begin
                            illegal    = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    AluSrcA     = 1'b1;
                    AluSrcB     = 2'b10;
                    ByteControl = byte_ctl(opcode);
                    state_next  = opcode[3] ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    mem_req     = 1'b1;
                    IorD        = 1'b1;
                    ByteControl = byte_ctl(opcode);
                    Arith_u     = unsigned_load;
                    if (mem_ready) begin
                        state_next = MEMWB;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = FETCH;
                    end
                end
                MEMWB: begin
                    RegWrite    = 1'b1;
                    MemtoReg    = 1'b1;
                    ByteControl = byte_ctl(opcode);
                    Arith_u     = unsigned_load;
                    instr_done  = 1'b1;
                    state_next  = FETCH;
                end
                MEMWR: begin
                    mem_req     = 1'b1;
                    IorD        = 1'b1;
                    MemWrite    = 1'b1;
                    ByteControl = byte_ctl(opcode);
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = FETCH;
                    end
                end
                EXEC: begin
                    AluSrcA    = 1'b1;
                    alu_opcode = (opcode == 6'd0) ? 5'b00010 : 5'b01010;
                    state_next = ALUWB;
                end
                ALUWB: begin
                    RegDst      = 1'b1;
                    RegWrite    = 1'b1;
                    ByteControl = 4'b1111;
                    alu_opcode  = (opcode == 6'd0) ? 5'b00010 : 5'b01010;
                    instr_done  = 1'b1;
                    state_next  = FETCH;
                end
                BRANCH: begin
                    AluSrcA    = 1'b1;
                    alu_opcode = 5'b00011;
                    Branch     = 1'b1;
                    PCSrc      = 2'b01;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                IEXEC, IWB: begin
                    AluSrcA    = 1'b1;
                    AluSrcB    = 2'b10;
                    alu_opcode = imm_alu(opcode);
                    Arith_u    = (opcode == 6'd12) || (opcode == 6'd13) || (opcode == 6'd14);
                    if (state == IWB) begin
                        RegWrite   = 1'b1;
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = IWB;
                    end
                end
                JUMP: begin
                    PCSrc      = 2'b10;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    link       = (opcode == 6'd3);
                    RegWrite   = (opcode == 6'd3);
                    state_next = FETCH;
                end
                JREG: begin
                    PCSrc      = 2'b11;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    link       = (funct == 6'd9);
                    RegWrite   = (funct == 6'd9);
                    RegDst     = (funct == 6'd9);
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed and randomized instruction streams
// checked every cycle against a per-instruction step-plan model, on an untimed and a MAX_WAIT=4 instance.
module tb_mips_multicycle_ctrl;

    typedef enum int {S_F, S_D, S_A, S_R, S_W, S_S, S_E, S_AW, S_B, S_I, S_IW, S_J, S_JR} step_t;
    typedef step_t plan_t[$];

    logic       clk = 1'b0;
    logic       rst0, rst4, mem_ready;
    logic [5:0] opcode, funct;
    wire  [27:0] o0, o4;
    logic [27:0] obs;
    int checks = 0;
    int errors = 0;
    int ncyc, done_seen;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MAX_WAIT(0), .WAIT_W(8)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(o0[27]), .IorD(o0[26]), .MemWrite(o0[25]), .IRWrite(o0[24]), .PCWrite(o0[23]),
        .Branch(o0[22]), .PCSrc(o0[21:20]), .AluSrcA(o0[19]), .AluSrcB(o0[18:17]), .RegDst(o0[16]),
        .MemtoReg(o0[15]), .RegWrite(o0[14]), .link(o0[13]), .Arith_u(o0[12]), .ByteControl(o0[11:8]),
        .alu_opcode(o0[7:3]), .instr_done(o0[2]), .illegal(o0[1]), .bus_err(o0[0]));

    mips_multicycle_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut4 (
        .clk(clk), .rst(rst4), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(o4[27]), .IorD(o4[26]), .MemWrite(o4[25]), .IRWrite(o4[24]), .PCWrite(o4[23]),
        .Branch(o4[22]), .PCSrc(o4[21:20]), .AluSrcA(o4[19]), .AluSrcB(o4[18:17]), .RegDst(o4[16]),
        .MemtoReg(o4[15]), .RegWrite(o4[14]), .link(o4[13]), .Arith_u(o4[12]), .ByteControl(o4[11:8]),
        .alu_opcode(o4[7:3]), .instr_done(o4[2]), .illegal(o4[1]), .bus_err(o4[0]));

    // Sequence of steps an instruction walks through after its fetch.
    function automatic plan_t plan_for(input logic [5:0] op, input logic [5:0] fn);
        plan_t p;
        p.push_back(S_D);
        if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) p.push_back(S_JR);
        else if (op == 6'd0 || op == 6'd28) begin p.push_back(S_E); p.push_back(S_AW); end
        else if (op inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37}) begin
            p.push_back(S_A); p.push_back(S_R); p.push_back(S_W);
        end
        else if (op inside {6'd40, 6'd41, 6'd43}) begin p.push_back(S_A); p.push_back(S_S); end
        else if (op inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7}) p.push_back(S_B);
        else if (op >= 6'd8 && op <= 6'd15) begin p.push_back(S_I); p.push_back(S_IW); end
        else if (op == 6'd2 || op == 6'd3) p.push_back(S_J);
        return p;
    endfunction

    function automatic logic [27:0] expv(input step_t s, input logic [5:0] op, input logic [5:0] fn,
                                         input logic rdy, input bit tmo);
        logic mreq = 0, iord = 0, mwr = 0, irw = 0, pcw = 0, br = 0, asa = 0, rdst = 0;
        logic m2r = 0, rw = 0, lnk = 0, au = 0, done = 0, ill = 0, berr = 0;
        logic [1:0] pcs = 0, asb = 0;
        logic [3:0] bc = 0, bsize;
        logic [4:0] alu = 0, ialu;
        bit legal, uload, ulogic;
        legal  = op inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                            28, 32, 33, 35, 36, 37, 40, 41, 43};
        bsize  = (op == 35 || op == 43) ? 4'hF : (op == 33 || op == 37 || op == 41) ? 4'h3 : 4'h1;
        uload  = (op == 36 || op == 37);
        ulogic = (op == 12 || op == 13 || op == 14);
        case (op)
            6'd10: ialu = 7;  6'd11: ialu = 8;  6'd12: ialu = 4;
            6'd13: ialu = 5;  6'd14: ialu = 6;  6'd15: ialu = 9;
            default: ialu = 0;
        endcase
        case (s)
            S_F:  begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; berr = tmo; end
            S_D:  begin asb = 2'b11; ill = !legal; end
            S_A:  begin asa = 1; asb = 2'b10; bc = bsize; end
            S_R:  begin mreq = 1; iord = 1; bc = bsize; au = uload; berr = tmo; end
            S_W:  begin rw = 1; m2r = 1; bc = bsize; au = uload; done = 1; end
            S_S:  begin mreq = 1; iord = 1; mwr = 1; bc = bsize; done = rdy; berr = tmo; end
            S_E:  begin asa = 1; alu = (op == 0) ? 5'd2 : 5'd10; end
            S_AW: begin rdst = 1; rw = 1; bc = 4'hF; alu = (op == 0) ? 5'd2 : 5'd10; done = 1; end
            S_B:  begin asa = 1; alu = 5'd3; br = 1; pcs = 2'b01; done = 1; end
            S_I:  begin asa = 1; asb = 2'b10; alu = ialu; au = ulogic; end
            S_IW: begin asa = 1; asb = 2'b10; alu = ialu; au = ulogic; rw = 1; done = 1; end
            S_J:  begin pcs = 2'b10; pcw = 1; done = 1; lnk = (op == 3); rw = (op == 3); end
            S_JR: begin pcs = 2'b11; pcw = 1; done = 1; lnk = (fn == 9); rw = (fn == 9); rdst = (fn == 9); end
            default: ;
        endcase
        return {mreq, iord, mwr, irw, pcw, br, pcs, asa, asb, rdst, m2r, rw, lnk, au, bc, alu, done, ill, berr};
    endfunction

    task automatic cyc(input int sel, input logic rdy, input logic [27:0] ex, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        obs = (sel != 0) ? o4 : o0;
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s dut%0d op=%0d fn=%0d observed=%h expected=%h", tag, sel, opcode, funct, obs, ex);
        end
        if (obs[2] === 1'b1) done_seen++;
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic mem_phase(input int sel, input step_t s, input int w, output bit ok);
        int mw;
        logic rdy;
        bit tmo;
        mw = (sel != 0) ? 4 : 0;
        ok = 0;
        for (int k = 0; k <= w; k++) begin
            rdy = (k == w);
            tmo = (mw != 0) && (k == mw - 1) && !rdy;
            cyc(sel, rdy, expv(s, opcode, funct, rdy, tmo), s.name());
            if (rdy) ok = 1;
            if (rdy || tmo) break;
        end
    endtask

    task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mwt, output int cycles, output int dones);
        plan_t plan;
        bit ok;
        ncyc = 0;
        done_seen = 0;
        opcode = op;
        funct = fn;
        mem_phase(sel, S_F, fw, ok);
        if (ok) begin
            plan = plan_for(op, fn);
            foreach (plan[i]) begin
                if (plan[i] == S_R || plan[i] == S_S) begin
                    mem_phase(sel, plan[i], mwt, ok);
                    if (!ok) break;
                end else begin
                    cyc(sel, 1'($urandom), expv(plan[i], op, fn, 1'b1, 1'b0), plan[i].name());
                end
            end
        end
        cycles = ncyc;
        dones = done_seen;
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    logic [5:0] ops [0:27] = '{6'd0, 6'd28, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43,
                               6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                               6'd13, 6'd14, 6'd15, 6'd2, 6'd3, 6'd16, 6'd17, 6'd63};

    initial begin
        int cy, dn;
        logic [5:0] op, fn;
        rst0 = 1; rst4 = 1; mem_ready = 1; opcode = 0; funct = 0;
        @(posedge clk); #1;

        // Both instances in reset: every output low.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1'b1, 28'h0, "reset_dut0");
            checks++;
            assert (o4 === 28'h0) else begin
                errors++;
                $error("FAIL reset_dut4 observed=%h expected=%h", o4, 28'h0);
            end
        end

        // Untimed instance: directed programs.
        rst0 = 0;
        run_instr(0, 6'd35, 6'd0, 0, 0, cy, dn);
        chk_int("lw_cycles", cy, 5);
        chk_int("lw_done", dn, 1);
        run_instr(0, 6'd36, 6'd0, 0, 3, cy, dn);
        chk_int("lbu_wait_cycles", cy, 8);
        run_instr(0, 6'd0, 6'd9, 0, 0, cy, dn);
        chk_int("jalr_cycles", cy, 3);
        run_instr(0, 6'd0, 6'd32, 0, 0, cy, dn);
        chk_int("rtype_cycles", cy, 4);
        run_instr(0, 6'd43, 6'd0, 0, 0, cy, dn);
        chk_int("sw_cycles", cy, 4);
        run_instr(0, 6'd13, 6'd0, 0, 0, cy, dn);
        chk_int("ori_cycles", cy, 4);
        run_instr(0, 6'd3, 6'd0, 0, 0, cy, dn);
        chk_int("jal_cycles", cy, 3);
        run_instr(0, 6'd16, 6'd0, 0, 0, cy, dn);
        chk_int("illegal_cycles", cy, 2);
        chk_int("illegal_done", dn, 0);
        run_instr(0, 6'd0, 6'd32, 20, 0, cy, dn);
        chk_int("long_fetch_wait_cycles", cy, 24);

        // Reset in EXEC of an R-type abandons it; the next cycle is a fresh fetch.
        opcode = 6'd0; funct = 6'd34;
        cyc(0, 1'b1, expv(S_F, 6'd0, 6'd34, 1'b1, 1'b0), "mid_rst_fetch");
        cyc(0, 1'b1, expv(S_D, 6'd0, 6'd34, 1'b1, 1'b0), "mid_rst_decode");
        rst0 = 1;
        cyc(0, 1'b1, 28'h0, "mid_rst_exec");
        rst0 = 0;
        cyc(0, 1'b0, expv(S_F, 6'd0, 6'd34, 1'b0, 1'b0), "post_rst_fetch");

        // MAX_WAIT=4 instance: store timeout, then ready arriving on the last allowed cycle.
        rst0 = 1; rst4 = 0;
        run_instr(1, 6'd43, 6'd0, 0, 10, cy, dn);
        chk_int("sw_timeout_cycles", cy, 7);
        chk_int("sw_timeout_done", dn, 0);
        run_instr(1, 6'd43, 6'd0, 0, 3, cy, dn);
        chk_int("sw_late_ready_cycles", cy, 7);
        chk_int("sw_late_ready_done", dn, 1);
        run_instr(1, 6'd0, 6'd32, 5, 0, cy, dn);
        chk_int("fetch_timeout_cycles", cy, 4);

        // Randomized streams on both instances.
        for (int sel = 1; sel >= 0; sel--) begin
            rst0 = (sel != 0);
            rst4 = (sel == 0);
            for (int n = 0; n < 250; n++) begin
                op = ops[$urandom_range(0, 27)];
                fn = 6'($urandom);
                if (op == 6'd0 && $urandom_range(0, 2) == 0) fn = ($urandom_range(0, 1) != 0) ? 6'd9 : 6'd8;
                if (sel != 0)
                    run_instr(1, op, fn, $urandom_range(0, 4) == 0 ? $urandom_range(0, 5) : 0,
                              $urandom_range(0, 5), cy, dn);
                else
                    run_instr(0, op, fn, $urandom_range(0, 6), $urandom_range(0, 6), cy, dn);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
